multi_lane_gate_controller: RTL

Parametrised successor to the single-lane smart gate controller. It runs `NUM_LANES` independent entry-gate FSMs against one shared capacity pool, with payment-clear timeouts, exit tracking and a saturating total-entry counter. It sits between the per-lane sensor/payment front-ends and the gate actuators and traffic lights.

---
 rtl/gate_pkg.sv | 23 ++
 rtl/gate_lane_fsm.sv | 109 ++++++++++
 rtl/multi_lane_gate_controller.sv | 120 ++++++++++++
 3 files changed

// File: rtl/gate_pkg.sv
// Shared types for the multi-lane gate controller: lane FSM states and
// traffic-light encodings.
package gate_pkg;

    typedef enum logic [2:0] {
        LS_IDLE,
        LS_CHECK,
        LS_WAIT_CLR,
        LS_ABORT,
        LS_OPEN,
        LS_HOLD,
        LS_WARN,
        LS_CLOSE
    } lane_state_e;

    // Light vector ordering is {red, yellow, green}; exactly one bit is set.
    typedef logic [2:0] light_t;

    localparam light_t LIGHT_RED    = 3'b100;
    localparam light_t LIGHT_YELLOW = 3'b010;
    localparam light_t LIGHT_GREEN  = 3'b001;

endpackage

// File: rtl/gate_lane_fsm.sv
// One entry lane: payment check, wait for a clear path (with timeout),
// then the open / hold / warn / close sequence.
module gate_lane_fsm
    import gate_pkg::*;
#(
    parameter int PAY_WAIT  = 2,
    parameter int OPEN_HOLD = 3,
    parameter int CLEAR_TMO = 16
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic i_grant,
    input  logic i_clear,
    output logic o_idle,
    output logic o_red,
    output logic o_yellow,
    output logic o_green,
    output logic o_gate_open,
    output logic o_gate_close,
    output logic o_abort,
    output logic o_entering_open,
    output logic o_entering_abort
);

    localparam int TMR_MAX_A = (PAY_WAIT > OPEN_HOLD) ? PAY_WAIT : OPEN_HOLD;
    localparam int TMR_MAX   = (TMR_MAX_A > CLEAR_TMO) ? TMR_MAX_A : CLEAR_TMO;
    localparam int TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    lane_state_e        r_state;
    lane_state_e        w_state_n;
    logic [TMR_W-1:0]   r_tmr;
    logic [TMR_W-1:0]   w_tmr_n;
    light_t             w_light;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= LS_IDLE;
            r_tmr   <= '0;
        end else begin
            r_state <= w_state_n;
            r_tmr   <= w_tmr_n;
        end
    end

    // The timer only advances while staying in a timed state, so every state
    // entry sees it at zero.
    always_comb begin
        w_state_n        = r_state;
        w_tmr_n          = '0;
        w_light          = LIGHT_RED;
        o_idle           = 1'b0;
        o_gate_open      = 1'b0;
        o_gate_close     = 1'b0;
        o_abort          = 1'b0;
        o_entering_open  = 1'b0;
        o_entering_abort = 1'b0;
        case (r_state)
            LS_IDLE: begin
                o_idle = 1'b1;
                if (i_grant) w_state_n = LS_CHECK;
            end
            LS_CHECK: begin
                w_light = LIGHT_YELLOW;
                if (r_tmr == TMR_W'(PAY_WAIT - 1)) w_state_n = LS_WAIT_CLR;
                else                               w_tmr_n   = r_tmr + TMR_W'(1);
            end
            LS_WAIT_CLR: begin
                w_light = LIGHT_YELLOW;
                if (i_clear) begin
                    w_state_n       = LS_OPEN;
                    o_entering_open = 1'b1;
                end else if (r_tmr == TMR_W'(CLEAR_TMO - 1)) begin
                    w_state_n        = LS_ABORT;
                    o_entering_abort = 1'b1;
                end else begin
                    w_tmr_n = r_tmr + TMR_W'(1);
                end
            end
            LS_ABORT: begin
                o_abort   = 1'b1;
                w_state_n = LS_IDLE;
            end
            LS_OPEN: begin
                w_light     = LIGHT_GREEN;
                o_gate_open = 1'b1;
                w_state_n   = LS_HOLD;
            end
            LS_HOLD: begin
                w_light = LIGHT_GREEN;
                if (r_tmr == TMR_W'(OPEN_HOLD - 1)) w_state_n = LS_WARN;
                else                                w_tmr_n   = r_tmr + TMR_W'(1);
            end
            LS_WARN: begin
                w_light   = LIGHT_YELLOW;
                w_state_n = LS_CLOSE;
            end
            LS_CLOSE: begin
                o_gate_close = 1'b1;
                w_state_n    = LS_IDLE;
            end
            default: w_state_n = LS_IDLE;
        endcase
    end

    assign o_red    = w_light[2];
    assign o_yellow = w_light[1];
    assign o_green  = w_light[0];

endmodule

// File: rtl/multi_lane_gate_controller.sv
// Multi-lane entry controller: per-lane gate FSMs sharing one capacity pool,
// with slot reservation, exit tracking and a saturating entry counter.
module multi_lane_gate_controller
    import gate_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int CNT_W     = 8,
    parameter int CAPACITY  = 200,
    parameter int PAY_WAIT  = 2,
    parameter int OPEN_HOLD = 3,
    parameter int CLEAR_TMO = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic [NUM_LANES-1:0] car_i,
    input  logic [NUM_LANES-1:0] pay_ok_i,
    input  logic [NUM_LANES-1:0] clear_i,
    input  logic                 exit_i,
    input  logic                 cnt_reset_i,
    output logic [NUM_LANES-1:0] gate_open_o,
    output logic [NUM_LANES-1:0] gate_close_o,
    output logic [NUM_LANES-1:0] red_o,
    output logic [NUM_LANES-1:0] yellow_o,
    output logic [NUM_LANES-1:0] green_o,
    output logic [CNT_W-1:0]     car_count_o,
    output logic [CNT_W-1:0]     occupancy_o,
    output logic                 full_o,
    output logic [NUM_LANES-1:0] abort_o
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic [NUM_LANES-1:0] w_idle;
    logic [NUM_LANES-1:0] w_req;
    logic [NUM_LANES-1:0] w_grant;
    logic [NUM_LANES-1:0] w_enter_open;
    logic [NUM_LANES-1:0] w_enter_abort;
    logic [CNT_W-1:0]     w_occ_n;
    logic [CNT_W-1:0]     w_cnt_n;
    logic                 w_full_n;
    logic [CNT_W-1:0]     r_occ;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_full;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        gate_lane_fsm #(
            .PAY_WAIT (PAY_WAIT),
            .OPEN_HOLD(OPEN_HOLD),
            .CLEAR_TMO(CLEAR_TMO)
        ) u_lane (
            .clk_i           (clk_i),
            .reset_ni        (reset_ni),
            .i_grant         (w_grant[l]),
            .i_clear         (clear_i[l]),
            .o_idle          (w_idle[l]),
            .o_red           (red_o[l]),
            .o_yellow        (yellow_o[l]),
            .o_green         (green_o[l]),
            .o_gate_open     (gate_open_o[l]),
            .o_gate_close    (gate_close_o[l]),
            .o_abort         (abort_o[l]),
            .o_entering_open (w_enter_open[l]),
            .o_entering_abort(w_enter_abort[l])
        );
    end

    assign w_req = w_idle & car_i & pay_ok_i;

    // Lowest lane index wins while free slots remain; free slots come from
    // the registered occupancy, so a same-cycle exit helps only next cycle.
    always_comb begin
        int w_slots;
        w_grant = '0;
        w_slots = CAPACITY - int'(r_occ);
        for (int i = 0; i < NUM_LANES; i++) begin
            if (w_req[i] && (w_slots > 0)) begin
                w_grant[i] = 1'b1;
                w_slots    = w_slots - 1;
            end
        end
    end

    always_comb begin
        int w_n_grant;
        int w_n_abort;
        int w_n_open;
        int w_occ_sum;
        int w_cnt_sum;
        w_n_grant = 0;
        w_n_abort = 0;
        w_n_open  = 0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_n_grant = w_n_grant + int'(w_grant[i]);
            w_n_abort = w_n_abort + int'(w_enter_abort[i]);
            w_n_open  = w_n_open  + int'(w_enter_open[i]);
        end
        w_occ_sum = int'(r_occ) + w_n_grant - w_n_abort - int'(exit_i);
        w_occ_n   = (w_occ_sum < 0) ? '0 : CNT_W'(w_occ_sum);
        w_full_n  = (w_occ_n == CNT_W'(CAPACITY));
        w_cnt_sum = int'(r_cnt) + w_n_open;
        w_cnt_n   = (w_cnt_sum > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(w_cnt_sum);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_occ  <= '0;
            r_full <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_occ  <= w_occ_n;
            r_full <= w_full_n;
            r_cnt  <= cnt_reset_i ? '0 : w_cnt_n;
        end
    end

    assign occupancy_o = r_occ;
    assign full_o      = r_full;
    assign car_count_o = r_cnt;

endmodule
